// File: rtl/sevenseg_capture.sv
// Observer for a scanned 7-segment bus: waits for each scan slot to settle,
// then latches per-digit segments, decoded hex, dp and liveness into static registers.
module sevenseg_capture #(
    parameter int unsigned N_DIGITS      = 8,
    parameter int unsigned STABLE_CYCLES = 64,
    parameter int unsigned EPOCH_CYCLES  = 1048576,
    parameter bit          ACTIVE_LOW    = 1'b1,
    localparam int unsigned IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_DIGITS-1:0]   anode,
    input  logic [6:0]            cathode,
    input  logic                  dp,
    output logic [7*N_DIGITS-1:0] digit_seg,
    output logic [4*N_DIGITS-1:0] digit_hex,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [N_DIGITS-1:0]   digit_dp,
    output logic [N_DIGITS-1:0]   digit_live,
    output logic                  update_strobe,
    output logic [IDX_W-1:0]      update_idx
);

    localparam int unsigned     W       = 8 + N_DIGITS;
    localparam int unsigned     EP_W    = $clog2(EPOCH_CYCLES);
    localparam logic [7:0]      CNT_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0]      CNT_CAP = 8'(STABLE_CYCLES - 1);
    localparam logic [EP_W-1:0] EP_LAST = EP_W'(EPOCH_CYCLES - 1);

    logic [W-1:0]          pins_n;
    logic [W-1:0]          sync1_q, sync1_d;
    logic [W-1:0]          s_q, s_d;
    logic [W-1:0]          s_prev_q, s_prev_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [EP_W-1:0]       epoch_q, epoch_d;
    logic [7*N_DIGITS-1:0] seg_q, seg_d;
    logic [4*N_DIGITS-1:0] hex_q, hex_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   live_q, live_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic                  strobe_q, strobe_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [N_DIGITS-1:0]   s_anode;
    logic [6:0]            s_seg;
    logic                  s_dp;
    logic                  capture;
    logic                  wrap;
    logic [N_DIGITS-1:0]   cap_vec;
    logic [4:0]            dec;

    // Returns {valid, hex}; unknown patterns decode to invalid zero.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        decode = 5'h00;
        case (seg)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign pins_n = ACTIVE_LOW ? ~{dp, cathode, anode} : {dp, cathode, anode};

    always_comb begin
        sync1_d  = pins_n;
        s_d      = sync1_q;
        s_prev_d = s_q;
        s_anode  = s_q[N_DIGITS-1:0];
        s_seg    = s_q[N_DIGITS +: 7];
        s_dp     = s_q[W-1];
        dec      = decode(s_seg);

        if (s_q != s_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // Firing one count before saturation gives exactly one capture per stable run.
        capture = (s_q == s_prev_q) && (cnt_q == CNT_CAP) && $onehot(s_anode);
        cap_vec = capture ? s_anode : '0;

        seg_d    = seg_q;
        hex_d    = hex_q;
        valid_d  = valid_q;
        dp_d     = dp_q;
        idx_d    = idx_q;
        strobe_d = capture;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (cap_vec[i]) begin
                seg_d[7*i +: 7] = s_seg;
                hex_d[4*i +: 4] = dec[3:0];
                valid_d[i]      = dec[4];
                dp_d[i]         = s_dp;
                idx_d           = IDX_W'(i);
            end
        end

        wrap    = (epoch_q == EP_LAST);
        epoch_d = wrap ? '0 : epoch_q + EP_W'(1);
        if (wrap) begin
            live_d = seen_q | cap_vec;
            seen_d = cap_vec;
        end else begin
            live_d = live_q;
            seen_d = seen_q | cap_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            s_q      <= '0;
            s_prev_q <= '0;
            cnt_q    <= '0;
            epoch_q  <= '0;
            seg_q    <= '0;
            hex_q    <= '0;
            valid_q  <= '0;
            dp_q     <= '0;
            live_q   <= '0;
            seen_q   <= '0;
            strobe_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            s_q      <= s_d;
            s_prev_q <= s_prev_d;
            cnt_q    <= cnt_d;
            epoch_q  <= epoch_d;
            seg_q    <= seg_d;
            hex_q    <= hex_d;
            valid_q  <= valid_d;
            dp_q     <= dp_d;
            live_q   <= live_d;
            seen_q   <= seen_d;
            strobe_q <= strobe_d;
            idx_q    <= idx_d;
        end
    end

    assign digit_seg     = seg_q;
    assign digit_hex     = hex_q;
    assign digit_valid   = valid_q;
    assign digit_dp      = dp_q;
    assign digit_live    = live_q;
    assign update_strobe = strobe_q;
    assign update_idx    = idx_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: history-based reference model (a capture happens when
// the sampled pins form a run of exactly STABLE+1 equal samples ending two edges back).
module tb_sevenseg_capture;

    localparam int N  = 8;
    localparam int ST = 64;
    localparam int EP = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  anode = 8'hFF;
    logic [6:0]  cathode = 7'h7F;
    logic        dp = 1'b1;
    logic [55:0] digit_seg;
    logic [31:0] digit_hex;
    logic [7:0]  digit_valid, digit_dp, digit_live;
    logic        update_strobe;
    logic [2:0]  update_idx;

    int errors = 0;
    int checks = 0;
    int dut_strobes = 0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sevenseg_capture #(
        .N_DIGITS(N), .STABLE_CYCLES(ST), .EPOCH_CYCLES(EP), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .anode(anode), .cathode(cathode), .dp(dp),
        .digit_seg(digit_seg), .digit_hex(digit_hex), .digit_valid(digit_valid),
        .digit_dp(digit_dp), .digit_live(digit_live),
        .update_strobe(update_strobe), .update_idx(update_idx)
    );

    always #5 clk = ~clk;

    // Reference model state (active-high view of the pins)
    logic [15:0] hist[$];
    logic [55:0] m_seg = '0;
    logic [31:0] m_hex = '0;
    logic [7:0]  m_valid = '0, m_dp = '0, m_live = '0, m_seen = '0, m_onehot;
    logic        m_strobe = 1'b0, m_cap;
    logic [15:0] m_ref;
    int          m_idx = 0;
    int          m_n = 0;

    function automatic logic [15:0] hist_at(int j);
        if (hist.size() > j) return hist[hist.size() - 1 - j];
        return '0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            hist.delete();
            m_seg = '0; m_hex = '0; m_valid = '0; m_dp = '0;
            m_live = '0; m_seen = '0; m_strobe = 1'b0; m_n = 0;
        end else begin
            hist.push_back({~dp, ~cathode, ~anode});
            if (hist.size() > ST + 8) void'(hist.pop_front());
            m_ref = hist_at(2);
            m_cap = ($countones(m_ref[7:0]) == 1) && (hist_at(ST + 3) != m_ref);
            for (int i = 1; i <= ST; i++) if (hist_at(2 + i) != m_ref) m_cap = 1'b0;
            m_onehot = m_cap ? m_ref[7:0] : 8'h00;
            m_strobe = m_cap;
            for (int d = 0; d < N; d++) begin
                if (m_onehot[d]) begin
                    m_idx = d;
                    m_seg[7*d +: 7] = m_ref[14:8];
                    m_dp[d] = m_ref[15];
                    m_hex[4*d +: 4] = 4'h0;
                    m_valid[d] = 1'b0;
                    for (int g = 0; g < 16; g++) begin
                        if (glyph_tab[g] == m_ref[14:8]) begin
                            m_hex[4*d +: 4] = 4'(g);
                            m_valid[d] = 1'b1;
                        end
                    end
                end
            end
            m_n++;
            if (m_n % EP == 0) begin
                m_live = m_seen | m_onehot;
                m_seen = m_onehot;
            end else begin
                m_seen = m_seen | m_onehot;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (update_strobe === 1'b1) dut_strobes++;
    end

    task automatic drive(input logic [7:0] an_hi, input logic [6:0] seg_hi, input logic dp_hi);
        anode   = ~an_hi;
        cathode = ~seg_hi;
        dp      = ~dp_hi;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        drive(8'(1 << $urandom_range(7)), 7'($urandom), 1'($urandom));
        repeat (3) @(negedge clk);
        checks++;
        if ({digit_seg, digit_hex, digit_valid, digit_dp, digit_live, update_idx} !== '0) begin
            errors++; $display("FAIL reset_outputs: got seg=%h hex=%h valid=%h dp=%h live=%h idx=%0d want all 0",
                               digit_seg, digit_hex, digit_valid, digit_dp, digit_live, update_idx);
        end
        checks++;
        if (update_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", update_strobe); end
        drive(8'h01, 7'h3F, 1'b0);
        dut_strobes = 0;
        rst_n = 1'b1;
        lat = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (update_strobe === 1'b1) begin lat = e; break; end
        end
        checks++;
        if (lat != ST + 3) begin errors++; $display("FAIL first_latency: got %0d want %0d", lat, ST + 3); end
        checks++;
        if (update_idx !== 3'd0) begin errors++; $display("FAIL first_idx: got %0d want 0", update_idx); end
        checks++;
        if (digit_hex[3:0] !== 4'h0 || digit_valid[0] !== 1'b1) begin
            errors++; $display("FAIL first_decode: got hex=%h valid=%b want 0/1", digit_hex[3:0], digit_valid[0]);
        end
        repeat (300) @(negedge clk);
        checks++;
        if (dut_strobes != 1) begin errors++; $display("FAIL static_strobes: got %0d want 1", dut_strobes); end
    endtask

    task automatic test_scan();
        logic [6:0] prev;
        int base;
        prev = glyph_tab[0];
        for (int sw = 0; sw < 2; sw++) begin
            base = dut_strobes;
            for (int d = 0; d < N; d++) begin
                drive(8'(1 << d), prev, 1'b0);
                repeat (3) @(negedge clk);
                drive(8'(1 << d), glyph_tab[d + 1], 1'b0);
                prev = glyph_tab[d + 1];
                repeat (200) @(negedge clk);
            end
            checks++;
            if (dut_strobes - base != 8) begin errors++; $display("FAIL sweep_strobes: got %0d want 8", dut_strobes - base); end
            checks++;
            if (digit_hex !== 32'h87654321) begin errors++; $display("FAIL sweep_hex: got %h want 87654321", digit_hex); end
            checks++;
            if (digit_valid !== 8'hFF) begin errors++; $display("FAIL sweep_valid: got %h want ff", digit_valid); end
            checks++;
            if (digit_seg !== m_seg) begin errors++; $display("FAIL sweep_seg: got %h want %h", digit_seg, m_seg); end
        end
    endtask

    task automatic test_multi_anode();
        int base;
        base = dut_strobes;
        drive(8'h03, 7'h5B, 1'b0);
        repeat (500) @(negedge clk);
        drive(8'h00, 7'h06, 1'b1);
        repeat (500) @(negedge clk);
        checks++;
        if (dut_strobes != base) begin errors++; $display("FAIL multi_strobes: got %0d want 0", dut_strobes - base); end
        checks++;
        if (digit_hex !== 32'h87654321) begin errors++; $display("FAIL multi_hex: got %h want 87654321", digit_hex); end
        checks++;
        if (digit_seg !== m_seg || digit_dp !== 8'h00) begin
            errors++; $display("FAIL multi_regs: got seg=%h dp=%h want seg=%h dp=00", digit_seg, digit_dp, m_seg);
        end
    endtask

    task automatic test_invalid_glyph();
        drive(8'h08, 7'h49, 1'b1);
        repeat (100) @(negedge clk);
        checks++;
        if (digit_seg[27:21] !== 7'h49) begin errors++; $display("FAIL inval_seg: got %h want 49", digit_seg[27:21]); end
        checks++;
        if (digit_valid[3] !== 1'b0 || digit_hex[15:12] !== 4'h0) begin
            errors++; $display("FAIL inval_decode: got valid=%b hex=%h want 0/0", digit_valid[3], digit_hex[15:12]);
        end
        checks++;
        if (digit_dp[3] !== 1'b1) begin errors++; $display("FAIL inval_dp: got %b want 1", digit_dp[3]); end
    endtask

    task automatic test_liveness();
        logic [6:0] prev;
        int cyc, drop;
        prev = 7'h49;
        cyc = 0;
        drop = -1;
        for (int sw = 0; sw < 10; sw++) begin
            for (int d = 0; d < N; d++) begin
                if (sw >= 3 && sw < 7 && d == 5) continue;
                for (int c = 0; c < 93; c++) begin
                    drive(8'(1 << d), (c < 3) ? prev : glyph_tab[d], 1'b0);
                    @(negedge clk);
                    checks++;
                    if (digit_live !== m_live) begin errors++; $display("FAIL live_track: got %h want %h", digit_live, m_live); end
                    checks++;
                    if (update_strobe !== m_strobe) begin errors++; $display("FAIL live_strobe: got %b want %b", update_strobe, m_strobe); end
                    if (sw >= 3) begin
                        cyc++;
                        if (drop < 0 && digit_live[5] === 1'b0) drop = cyc;
                    end
                end
                prev = glyph_tab[d];
            end
            if (sw == 2) begin
                checks++;
                if (digit_live !== 8'hFF) begin errors++; $display("FAIL live_all: got %h want ff", digit_live); end
            end
            if (sw == 6) begin
                checks++;
                if (drop < 1 || drop > 2 * EP) begin errors++; $display("FAIL live_drop: got %0d cycles want 1..%0d", drop, 2 * EP); end
                checks++;
                if (digit_live !== 8'hDF) begin errors++; $display("FAIL live_others: got %h want df", digit_live); end
            end
        end
        checks++;
        if (digit_live !== 8'hFF) begin errors++; $display("FAIL live_resume: got %h want ff", digit_live); end
    endtask

    task automatic test_random();
        logic [7:0] an;
        logic [6:0] sg;
        logic       dpv;
        int         hold;
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(7) == 0) an = 8'($urandom);
            else an = 8'(1 << $urandom_range(7));
            if ($urandom_range(3) == 0) sg = 7'($urandom);
            else sg = glyph_tab[$urandom_range(15)];
            dpv = 1'($urandom);
            hold = int'($urandom_range(150, 1));
            drive(an, sg, dpv);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                checks++;
                if (update_strobe !== m_strobe) begin errors++; $display("FAIL rand_strobe: got %b want %b", update_strobe, m_strobe); end
                if (m_strobe) begin
                    checks++;
                    if (update_idx !== 3'(m_idx)) begin errors++; $display("FAIL rand_idx: got %0d want %0d", update_idx, m_idx); end
                end
            end
        end
        repeat (80) @(negedge clk);
        checks++;
        if (digit_seg !== m_seg) begin errors++; $display("FAIL rand_seg: got %h want %h", digit_seg, m_seg); end
        checks++;
        if (digit_hex !== m_hex || digit_valid !== m_valid) begin
            errors++; $display("FAIL rand_decode: got %h/%h want %h/%h", digit_hex, digit_valid, m_hex, m_valid);
        end
        checks++;
        if (digit_dp !== m_dp || digit_live !== m_live) begin
            errors++; $display("FAIL rand_dp_live: got %h/%h want %h/%h", digit_dp, digit_live, m_dp, m_live);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        drive(8'h40, 7'h77, 1'b0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({digit_seg, digit_hex, digit_valid, digit_dp, digit_live, update_strobe} !== '0) begin
            errors++; $display("FAIL midreset_async: got seg=%h hex=%h valid=%h dp=%h live=%h want all 0",
                               digit_seg, digit_hex, digit_valid, digit_dp, digit_live);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lat = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (update_strobe === 1'b1) begin lat = e; break; end
        end
        checks++;
        if (lat != ST + 3) begin errors++; $display("FAIL midreset_latency: got %0d want %0d", lat, ST + 3); end
        checks++;
        if (update_idx !== 3'd6 || digit_hex[27:24] !== 4'hA || digit_valid !== 8'h40) begin
            errors++; $display("FAIL midreset_capture: got idx=%0d hex=%h valid=%h want 6/a/40",
                               update_idx, digit_hex[27:24], digit_valid);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_multi_anode();
        test_invalid_glyph();
        test_liveness();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
